// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer: fetch/launch/wait/write-back controller for the calculator datapath.
// Optional overflow trap enabled by defining CALC_SEQ_OVF_TRAP_EN.
module calc_op_sequencer #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int OP_W    = 3,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [OP_W-1:0]   op,
  input  logic              use_ram,
  input  logic              src_sel,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              alu_done,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_ovf,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [DATA_W-1:0] num_ram,
  output logic              rd,
  output logic              sw,
  output logic [OP_W-1:0]   alu_op,
  output logic              alu_start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] result
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LATCH, S_EXEC, S_WAIT, S_WB, S_DONE} state_t;
  state_t            r_state, w_nxt;
  logic [OP_W-1:0]   r_op, w_op;
  logic              r_use, r_src, r_wb_en, w_use, w_src, w_acc, w_to, w_trap, w_mid;
  logic [ADDR_W-1:0] r_wb_addr;
  logic [CW-1:0]     r_cnt;
  // Outputs are registered from the next state, so w_* carry the values latched on accept.
  always_comb begin
    w_acc = r_state == S_IDLE && start;
    w_op  = w_acc ? op : r_op;
    w_use = w_acc ? use_ram : r_use;
    w_src = w_acc ? src_sel : r_src;
    w_to  = r_cnt == CW'(TIMEOUT);
`ifdef CALC_SEQ_OVF_TRAP_EN
    w_trap = alu_ovf;
`else
    w_trap = alu_ovf & 1'b0;
`endif
    w_nxt = S_IDLE;
    case (r_state)
      S_IDLE:  w_nxt = start ? (use_ram ? S_FETCH : S_EXEC) : S_IDLE;
      S_FETCH: w_nxt = S_LATCH;
      S_LATCH: w_nxt = S_EXEC;
      S_EXEC:  w_nxt = S_WAIT;
      S_WAIT:  w_nxt = alu_done ? (r_wb_en && !w_trap ? S_WB : S_DONE) : (w_to ? S_DONE : S_WAIT);
      S_WB:    w_nxt = S_DONE;
      default: w_nxt = S_IDLE;
    endcase
    w_mid = w_nxt inside {S_FETCH, S_LATCH, S_EXEC, S_WAIT};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_use     <= 1'b0;
      r_src     <= 1'b0;
      r_wb_en   <= 1'b0;
      r_wb_addr <= '0;
      r_cnt     <= '0;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
      num_ram   <= '0;
      rd        <= 1'b0;
      sw        <= 1'b0;
      alu_op    <= '0;
      alu_start <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      result    <= '0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= r_state == S_WAIT ? r_cnt + 1'b1 : '0;
      if (w_acc) begin
        r_op      <= op;
        r_use     <= use_ram;
        r_src     <= src_sel;
        r_wb_en   <= wb_en;
        r_wb_addr <= wb_addr;
        error     <= 1'b0;
      end
      if (r_state == S_LATCH) num_ram <= ram_rdata;
      if (r_state == S_WAIT && alu_done) result <= alu_result;
      if (r_state == S_WAIT && (alu_done ? w_trap : w_to)) error <= 1'b1;
      ram_addr  <= w_nxt == S_FETCH ? rd_addr : (w_nxt == S_WB ? r_wb_addr : '0);
      ram_we    <= w_nxt == S_WB;
      ram_wdata <= w_nxt == S_WB ? alu_result : '0;
      rd        <= w_mid && w_use;
      sw        <= w_mid && w_src;
      alu_op    <= (w_nxt == S_EXEC || w_nxt == S_WAIT) ? w_op : '0;
      alu_start <= w_nxt == S_EXEC;
      busy      <= w_nxt != S_IDLE;
      done      <= w_nxt == S_DONE;
    end
  end
endmodule

// File: tb/tb_calc_op_sequencer.sv
// tb_calc_op_sequencer: randomized and directed checks of calc_op_sequencer against a cycle-schedule model.
module tb_calc_op_sequencer;
  localparam int DW = 32, AW = 8, OW = 3, TO = 4;
`ifdef CALC_SEQ_OVF_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic start = 0, use_ram = 0, src_sel = 0, wb_en = 0, alu_done = 0, alu_ovf = 0;
  logic [OW-1:0] op = '0;
  logic [AW-1:0] rd_addr = '0, wb_addr = '0;
  logic [DW-1:0] ram_rdata = '0, alu_result = '0;
  logic [AW-1:0] ram_addr;
  logic ram_we, rd, sw, alu_start, busy, done, error;
  logic [DW-1:0] ram_wdata, num_ram, result;
  logic [OW-1:0] alu_op;
  logic [DW-1:0] mem [256];
  logic [DW-1:0] m_result = '0, m_num = '0;
  int checks = 0, errs = 0;

  calc_op_sequencer #(.DATA_W(DW), .ADDR_W(AW), .OP_W(OW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .use_ram(use_ram), .src_sel(src_sel),
    .rd_addr(rd_addr), .wb_en(wb_en), .wb_addr(wb_addr), .ram_rdata(ram_rdata),
    .alu_done(alu_done), .alu_result(alu_result), .alu_ovf(alu_ovf), .ram_addr(ram_addr),
    .ram_we(ram_we), .ram_wdata(ram_wdata), .num_ram(num_ram), .rd(rd), .sw(sw),
    .alu_op(alu_op), .alu_start(alu_start), .busy(busy), .done(done), .error(error),
    .result(result));

  always #5 clk = ~clk;
  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  // Expected schedule: optional 2 fetch cycles, EXEC, wn WAIT cycles, optional WB, DONE.
  task automatic run_op(input string tag, input logic u, input logic s, input logic [AW-1:0] ra,
                        input logic w, input logic [AW-1:0] wa, input logic [OW-1:0] o,
                        input int dly, input logic [DW-1:0] res, input logic ov,
                        input logic poke, input logic spur);
    bit tmo = dly > TO;
    int e_exec = u ? 3 : 1;
    int wn = tmo ? TO + 1 : dly + 1;
    bit e_err = tmo || (TRAP && ov);
    bit e_wb = w && !e_err;
    int e_wbc = e_exec + wn + 1;
    int e_done = e_wbc + (e_wb ? 1 : 0);
    int hit = tmo ? -1 : e_exec + 1 + dly;
    logic [DW-1:0] e_num = u ? mem[ra] : m_num;
    logic [DW-1:0] e_res = tmo ? m_result : res;
    int n_st = 0, st_c = -1, n_dn = 0, dn_c = -1, n_we = 0, we_c = -1, bad = 0;
    logic [AW-1:0] we_a = '0;
    logic [DW-1:0] we_d = '0;
    start = 1; use_ram = u; src_sel = s; rd_addr = ra; wb_en = w; wb_addr = wa; op = o;
    @(posedge clk); #1;
    start = 0; use_ram = 1'($urandom); src_sel = 1'($urandom); op = OW'($urandom);
    rd_addr = AW'($urandom); wb_en = 1'($urandom); wb_addr = AW'($urandom);
    for (int c = 1; c <= e_done + 2; c++) begin
      bit mid = c <= e_exec + wn;
      if (alu_start) begin n_st++; st_c = c; end
      if (done) begin n_dn++; dn_c = c; end
      if (ram_we) begin n_we++; we_c = c; we_a = ram_addr; we_d = ram_wdata; end
      if (rd !== (u && mid) || sw !== (s && mid) || busy !== (c <= e_done) ||
          alu_op !== ((c >= e_exec && mid) ? o : '0) || error !== (c >= e_done ? e_err : 1'b0) ||
          (c == 1 && u && ram_addr !== ra)) begin
        bad++;
        $display("  %s cycle %0d: rd=%b sw=%b busy=%b alu_op=%0d error=%b ram_addr=%h", tag, c, rd, sw, busy, alu_op, error, ram_addr);
      end
      alu_done = c == hit || (spur && c == e_exec);
      alu_result = c == hit ? res : $urandom;
      alu_ovf = c == hit ? ov : 1'($urandom);
      start = poke && c == 2;
      @(posedge clk); #1;
    end
    alu_done = 0; start = 0;
    checks++; if (bad !== 0) begin errs++; $display("FAIL %s trace: %0d bad cycles, want 0", tag, bad); end
    checks++; if (n_st !== 1 || st_c !== e_exec) begin errs++; $display("FAIL %s alu_start: %0d pulses at %0d, want 1 at %0d", tag, n_st, st_c, e_exec); end
    checks++; if (n_dn !== 1 || dn_c !== e_done) begin errs++; $display("FAIL %s done: %0d pulses at %0d, want 1 at %0d", tag, n_dn, dn_c, e_done); end
    checks++; if (n_we !== int'(e_wb)) begin errs++; $display("FAIL %s ram_we count: got %0d want %0d", tag, n_we, e_wb); end
    if (e_wb) begin
      checks++;
      if (we_c !== e_wbc || we_a !== wa || we_d !== res) begin
        errs++; $display("FAIL %s write: cyc %0d addr %h data %h, want cyc %0d addr %h data %h", tag, we_c, we_a, we_d, e_wbc, wa, res);
      end
    end
    checks++; if (num_ram !== e_num) begin errs++; $display("FAIL %s num_ram: got %h want %h", tag, num_ram, e_num); end
    checks++; if (result !== e_res) begin errs++; $display("FAIL %s result: got %h want %h", tag, result, e_res); end
    checks++; if (error !== e_err) begin errs++; $display("FAIL %s error after: got %b want %b", tag, error, e_err); end
    m_num = e_num; m_result = e_res;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 0 || done !== 0 || error !== 0) begin errs++; $display("FAIL reset flags: busy=%b done=%b error=%b want 0", busy, done, error); end
    checks++; if (ram_we !== 0 || ram_addr !== 0 || ram_wdata !== 0) begin errs++; $display("FAIL reset ram port: we=%b addr=%h wdata=%h want 0", ram_we, ram_addr, ram_wdata); end
    checks++; if (num_ram !== 0 || result !== 0) begin errs++; $display("FAIL reset data: num_ram=%h result=%h want 0", num_ram, result); end
    checks++; if (rd !== 0 || sw !== 0 || alu_start !== 0 || alu_op !== 0) begin errs++; $display("FAIL reset ctrl: rd=%b sw=%b alu_start=%b alu_op=%0d want 0", rd, sw, alu_start, alu_op); end
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 0 || done !== 0) begin errs++; $display("FAIL idle after reset: busy=%b done=%b want 0", busy, done); end
  endtask

  task automatic test_ram_slot_b();
    mem[8'h10] = 32'h0000_0007;
    run_op("ram_slot_b", 1, 1, 8'h10, 0, 8'h00, 3'd5, 0, 32'h1234_5678, 0, 0, 0);
  endtask

  task automatic test_write_back();
    run_op("write_back", 1, 0, 8'h33, 1, 8'h20, 3'd2, 0, 32'h0000_002A, 0, 0, 0);
    checks++; if (mem[8'h20] !== 32'h0000_002A) begin errs++; $display("FAIL write_back mem[20]: got %h want 0000002a", mem[8'h20]); end
  endtask

  task automatic test_no_ram();
    run_op("no_ram", 0, 0, 8'h44, 0, 8'h55, 3'd3, 1, 32'hCAFE_0001, 0, 0, 1);
  endtask

  task automatic test_timeout();
    run_op("timeout", 1, 1, 8'h01, 1, 8'h02, 3'd7, TO + 1, 32'h0, 0, 1, 0);
    run_op("after_timeout", 0, 1, 8'h00, 1, 8'h03, 3'd1, 0, 32'h0BAD_F00D, 0, 0, 0);
  endtask

  task automatic test_overflow();
    run_op("overflow", 0, 0, 8'h00, 1, 8'h40, 3'd4, 2, 32'h8000_0001, 1, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++)
      run_op("random", 1'($urandom), 1'($urandom), AW'($urandom), 1'($urandom), AW'($urandom),
             OW'($urandom), $urandom_range(TO + 1, 0), $urandom, $urandom_range(3, 0) == 0,
             1'($urandom), 1'($urandom));
  endtask

  task automatic test_reset_mid_op();
    int n_bad = 0;
    start = 1; use_ram = 1; src_sel = 0; rd_addr = 8'h05; wb_en = 1; wb_addr = 8'h06; op = 3'd6;
    @(posedge clk); #1;
    start = 0;
    for (int c = 1; c <= 4; c++) begin
      alu_done = c == 4; alu_result = 32'h5555_AAAA; alu_ovf = 0;
      @(posedge clk); #1;
    end
    alu_done = 0;
    checks++; if (ram_we !== 1) begin errs++; $display("FAIL reset_mid wb entry: ram_we=%b want 1", ram_we); end
    #2 rst = 1;
    #1;
    checks++; if (busy !== 0 || ram_we !== 0) begin errs++; $display("FAIL reset_mid async: busy=%b ram_we=%b want 0", busy, ram_we); end
    checks++; if (result !== 0 || num_ram !== 0 || ram_addr !== 0) begin errs++; $display("FAIL reset_mid data: result=%h num_ram=%h ram_addr=%h want 0", result, num_ram, ram_addr); end
    #2 rst = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (done !== 0 || ram_we !== 0 || busy !== 0) n_bad++;
    end
    checks++; if (n_bad !== 0) begin errs++; $display("FAIL reset_mid aftermath: %0d cycles with done/we/busy, want 0", n_bad); end
    m_result = '0; m_num = '0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    test_reset();
    test_ram_slot_b();
    test_write_back();
    test_no_ram();
    test_timeout();
    test_overflow();
    test_random();
    test_reset_mid_op();
    run_op("post_reset", 1, 0, 8'h77, 1, 8'h78, 3'd1, 1, 32'h0000_0099, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
